// File: rtl/vga_pkg.sv
// Shared screen geometry, colour codes and arbitration mode encodings for the
// VGA drawing path.
package vga_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned X_MAX    = SCREEN_W - 1;
    localparam int unsigned Y_MAX    = SCREEN_H - 1;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] COL_BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] COL_RED   = 3'b100;
    localparam logic [COLOUR_W-1:0] COL_GREEN = 3'b010;
    localparam logic [COLOUR_W-1:0] COL_WHITE = 3'b111;

    localparam int unsigned MODE_RR = 0;
    localparam int unsigned MODE_FP = 1;

    // Width of a channel index; never zero even for a single channel.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Per-channel pixel request bundle between drawing sources and the plot arbiter.
interface vga_plot_arbiter_if #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned X_W      = vga_pkg::X_W,
    parameter int unsigned Y_W      = vga_pkg::Y_W,
    parameter int unsigned COLOUR_W = vga_pkg::COLOUR_W
);

    logic [NUM_CH-1:0]          in_valid;
    logic [NUM_CH*X_W-1:0]      in_x;
    logic [NUM_CH*Y_W-1:0]      in_y;
    logic [NUM_CH*COLOUR_W-1:0] in_colour;
    logic [NUM_CH-1:0]          in_ready;

    modport master (
        output in_valid,
        output in_x,
        output in_y,
        output in_colour,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_x,
        input  in_y,
        input  in_colour,
        output in_ready
    );

endinterface

// File: rtl/rr_grant.sv
// Combinational one-hot grant: search the valid vector starting at ptr_i
// (or at 0 in fixed-priority mode), wrapping modulo NUM_CH.
module rr_grant #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ID_W   = 2
) (
    input  logic [NUM_CH-1:0] valid_i,
    input  logic [ID_W-1:0]   ptr_i,
    input  logic              fixed_prio_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [ID_W-1:0]   grant_id_o
);

    int unsigned base;
    int unsigned idx;
    logic        found;

    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        found      = 1'b0;
        idx        = 0;
        base       = fixed_prio_i ? 32'd0 : 32'(ptr_i);
        for (int i = 0; i < NUM_CH; i++) begin
            idx = base + 32'(i);
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && valid_i[ID_W'(idx)]) begin
                found                 = 1'b1;
                grant_o[ID_W'(idx)]   = 1'b1;
                grant_id_o            = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// N-channel pixel-plot arbiter in front of vga_adapter: one grant per cycle,
// registered plot output, off-screen pixels swallowed and counted.
module vga_plot_arbiter #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned X_W      = vga_pkg::X_W,
    parameter int unsigned Y_W      = vga_pkg::Y_W,
    parameter int unsigned COLOUR_W = vga_pkg::COLOUR_W,
    parameter int unsigned X_MAX    = vga_pkg::X_MAX,
    parameter int unsigned Y_MAX    = vga_pkg::Y_MAX,
    parameter int unsigned MODE     = vga_pkg::MODE_RR,
    localparam int unsigned ID_W    = vga_pkg::id_width(NUM_CH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    vga_plot_arbiter_if.slave   src,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic [ID_W-1:0]     grant_id,
    output logic [15:0]         clip_count
);

    import vga_pkg::*;

    logic [NUM_CH-1:0]   grant;
    logic [ID_W-1:0]     sel_id;
    logic [X_W-1:0]      sel_x;
    logic [Y_W-1:0]      sel_y;
    logic [COLOUR_W-1:0] sel_colour;
    logic                transfer;
    logic                in_bounds;

    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic                plot_q, plot_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic [ID_W-1:0]     gid_q, gid_d;
    logic [15:0]         clip_q, clip_d;

    rr_grant #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_rr_grant (
        .valid_i      (src.in_valid),
        .ptr_i        (ptr_q),
        .fixed_prio_i (MODE == MODE_FP),
        .grant_o      (grant),
        .grant_id_o   (sel_id)
    );

    // Reset gates ready so nothing is accepted on the reset edge.
    assign src.in_ready = (en && !reset) ? grant : '0;
    assign transfer     = |(src.in_valid & src.in_ready);

    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_id == ID_W'(i)) begin
                sel_x      = src.in_x[i*X_W +: X_W];
                sel_y      = src.in_y[i*Y_W +: Y_W];
                sel_colour = src.in_colour[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    assign in_bounds = (32'(sel_x) <= X_MAX) && (32'(sel_y) <= Y_MAX);

    always_comb begin
        ptr_d    = ptr_q;
        plot_d   = transfer && in_bounds;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        gid_d    = gid_q;
        clip_d   = clip_q;
        if (transfer) begin
            x_d      = sel_x;
            y_d      = sel_y;
            colour_d = sel_colour;
            gid_d    = sel_id;
            if (MODE != MODE_FP) begin
                ptr_d = (sel_id == ID_W'(NUM_CH - 1)) ? '0 : sel_id + 1'b1;
            end
            if (!in_bounds && clip_q != 16'hFFFF) begin
                clip_d = clip_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= '0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            gid_q    <= '0;
            clip_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            plot_q   <= plot_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            gid_q    <= gid_d;
            clip_q   <= clip_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign grant_id   = gid_q;
    assign clip_count = clip_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: a round-robin and a fixed-priority
// instance driven from vector tables plus hand sequences for reset/clip/enable.
module tb_vga_plot_arbiter;

    import vga_pkg::*;

    localparam int unsigned NumCh = 4;
    localparam int unsigned XW    = 8;
    localparam int unsigned YW    = 7;
    localparam int unsigned CW    = 3;
    localparam int unsigned IdW   = 2;

    typedef struct {
        logic              en;
        logic [NumCh-1:0]  valid;
        logic [NumCh-1:0]  exp_ready;
        logic              exp_plot;
        int unsigned       exp_gid;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic en;

    logic [XW-1:0]  rr_x, fp_x;
    logic [YW-1:0]  rr_y, fp_y;
    logic [CW-1:0]  rr_col, fp_col;
    logic           rr_plot, fp_plot;
    logic [IdW-1:0] rr_gid, fp_gid;
    logic [15:0]    rr_clip, fp_clip;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    vec_t rr_tab [16];
    vec_t fp_tab [7];

    always #5 clk = ~clk;

    vga_plot_arbiter_if #(.NUM_CH(NumCh), .X_W(XW), .Y_W(YW), .COLOUR_W(CW)) rr_if ();
    vga_plot_arbiter_if #(.NUM_CH(NumCh), .X_W(XW), .Y_W(YW), .COLOUR_W(CW)) fp_if ();

    vga_plot_arbiter #(
        .NUM_CH(NumCh), .X_W(XW), .Y_W(YW), .COLOUR_W(CW),
        .X_MAX(159), .Y_MAX(119), .MODE(MODE_RR)
    ) u_rr (
        .clk(clk), .reset(reset), .en(en), .src(rr_if.slave),
        .x(rr_x), .y(rr_y), .colour(rr_col), .plot(rr_plot),
        .grant_id(rr_gid), .clip_count(rr_clip)
    );

    vga_plot_arbiter #(
        .NUM_CH(NumCh), .X_W(XW), .Y_W(YW), .COLOUR_W(CW),
        .X_MAX(159), .Y_MAX(119), .MODE(MODE_FP)
    ) u_fp (
        .clk(clk), .reset(reset), .en(en), .src(fp_if.slave),
        .x(fp_x), .y(fp_y), .colour(fp_col), .plot(fp_plot),
        .grant_id(fp_gid), .clip_count(fp_clip)
    );

    function automatic logic [XW-1:0] dx(input int unsigned i);
        return XW'(20 + i);
    endfunction

    function automatic logic [YW-1:0] dy(input int unsigned i);
        return YW'(30 + i);
    endfunction

    function automatic logic [CW-1:0] dc(input int unsigned i);
        return CW'(i + 1);
    endfunction

    function automatic vec_t mk(input logic e, input logic [3:0] v, input logic [3:0] r,
                                input logic p, input int unsigned g);
        vec_t t;
        t.en        = e;
        t.valid     = v;
        t.exp_ready = r;
        t.exp_plot  = p;
        t.exp_gid   = g;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic set_defaults();
        for (int i = 0; i < NumCh; i++) begin
            rr_if.in_x[i*XW +: XW]      = dx(i);
            rr_if.in_y[i*YW +: YW]      = dy(i);
            rr_if.in_colour[i*CW +: CW] = dc(i);
            fp_if.in_x[i*XW +: XW]      = dx(i);
            fp_if.in_y[i*YW +: YW]      = dy(i);
            fp_if.in_colour[i*CW +: CW] = dc(i);
        end
    endtask

    task automatic set_ch(input int unsigned ch, input logic [XW-1:0] px,
                          input logic [YW-1:0] py, input logic [CW-1:0] pc);
        rr_if.in_x[ch*XW +: XW]      = px;
        rr_if.in_y[ch*YW +: YW]      = py;
        rr_if.in_colour[ch*CW +: CW] = pc;
    endtask

    task automatic apply_row(input bit fp, input vec_t r);
        en = r.en;
        if (fp) fp_if.in_valid = r.valid;
        else    rr_if.in_valid = r.valid;
        #1;
        chk("ready", fp ? fp_if.in_ready : rr_if.in_ready, r.exp_ready);
        @(posedge clk);
        #1;
        if (fp) begin
            chk("plot", fp_plot, r.exp_plot);
            chk("grant_id", fp_gid, r.exp_gid);
            chk("x", fp_x, dx(r.exp_gid));
            chk("y", fp_y, dy(r.exp_gid));
            chk("colour", fp_col, dc(r.exp_gid));
            chk("clip_count", fp_clip, 0);
        end else begin
            chk("plot", rr_plot, r.exp_plot);
            chk("grant_id", rr_gid, r.exp_gid);
            chk("x", rr_x, dx(r.exp_gid));
            chk("y", rr_y, dy(r.exp_gid));
            chk("colour", rr_col, dc(r.exp_gid));
            chk("clip_count", rr_clip, 0);
        end
    endtask

    initial begin
        // Round-robin: fairness over 8 cycles, gaps, en=0, wrap with skipped channels.
        rr_tab[0]  = mk(1'b1, 4'b1111, 4'b0001, 1'b1, 0);
        rr_tab[1]  = mk(1'b1, 4'b1111, 4'b0010, 1'b1, 1);
        rr_tab[2]  = mk(1'b1, 4'b1111, 4'b0100, 1'b1, 2);
        rr_tab[3]  = mk(1'b1, 4'b1111, 4'b1000, 1'b1, 3);
        rr_tab[4]  = mk(1'b1, 4'b1111, 4'b0001, 1'b1, 0);
        rr_tab[5]  = mk(1'b1, 4'b1111, 4'b0010, 1'b1, 1);
        rr_tab[6]  = mk(1'b1, 4'b1111, 4'b0100, 1'b1, 2);
        rr_tab[7]  = mk(1'b1, 4'b1111, 4'b1000, 1'b1, 3);
        rr_tab[8]  = mk(1'b1, 4'b1010, 4'b0010, 1'b1, 1);
        rr_tab[9]  = mk(1'b1, 4'b1010, 4'b1000, 1'b1, 3);
        rr_tab[10] = mk(1'b0, 4'b1111, 4'b0000, 1'b0, 3);
        rr_tab[11] = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 3);
        rr_tab[12] = mk(1'b1, 4'b1001, 4'b0001, 1'b1, 0);
        rr_tab[13] = mk(1'b1, 4'b1001, 4'b1000, 1'b1, 3);
        rr_tab[14] = mk(1'b1, 4'b1000, 4'b1000, 1'b1, 3);
        rr_tab[15] = mk(1'b1, 4'b0001, 4'b0001, 1'b1, 0);

        fp_tab[0]  = mk(1'b1, 4'b1010, 4'b0010, 1'b1, 1);
        fp_tab[1]  = mk(1'b1, 4'b1010, 4'b0010, 1'b1, 1);
        fp_tab[2]  = mk(1'b1, 4'b1010, 4'b0010, 1'b1, 1);
        fp_tab[3]  = mk(1'b1, 4'b1000, 4'b1000, 1'b1, 3);
        fp_tab[4]  = mk(1'b1, 4'b1111, 4'b0001, 1'b1, 0);
        fp_tab[5]  = mk(1'b1, 4'b1110, 4'b0010, 1'b1, 1);
        fp_tab[6]  = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1);

        reset          = 1'b1;
        en             = 1'b1;
        rr_if.in_valid = '1;
        fp_if.in_valid = '0;
        set_defaults();

        // Two reset cycles with every channel requesting.
        @(posedge clk);
        #1;
        chk("rst_ready_c1", rr_if.in_ready, 0);
        chk("rst_plot_c1", rr_plot, 0);
        @(posedge clk);
        #1;
        chk("rst_ready_c2", rr_if.in_ready, 0);
        chk("rst_plot_c2", rr_plot, 0);
        chk("rst_clip", rr_clip, 0);
        chk("rst_gid", rr_gid, 0);
        chk("rst_x", rr_x, 0);
        chk("rst_fp_plot", fp_plot, 0);
        reset = 1'b0;

        for (int k = 0; k < 16; k++) apply_row(1'b0, rr_tab[k]);

        // Mid-stream reset with the pointer at 2.
        rr_if.in_valid = 4'b1111;
        #1;
        chk("ms_ready_pre", rr_if.in_ready, 4'b0010);
        @(posedge clk);
        #1;
        chk("ms_gid_pre", rr_gid, 1);
        reset = 1'b1;
        #1;
        chk("ms_ready_rst", rr_if.in_ready, 0);
        @(posedge clk);
        #1;
        chk("ms_plot_rst", rr_plot, 0);
        chk("ms_gid_rst", rr_gid, 0);
        chk("ms_x_rst", rr_x, 0);
        reset = 1'b0;
        #1;
        chk("ms_ready_post", rr_if.in_ready, 4'b0001);
        @(posedge clk);
        #1;
        chk("ms_plot_post", rr_plot, 1);
        chk("ms_gid_post", rr_gid, 0);

        // Clipping on channel 2.
        rr_if.in_valid = 4'b0100;
        set_ch(2, 8'd160, 7'd10, COL_WHITE);
        #1;
        chk("clip1_ready", rr_if.in_ready, 4'b0100);
        @(posedge clk);
        #1;
        chk("clip1_plot", rr_plot, 0);
        chk("clip1_count", rr_clip, 1);
        chk("clip1_x", rr_x, 160);
        set_ch(2, 8'd5, 7'd120, COL_RED);
        #1;
        chk("clip2_ready", rr_if.in_ready, 4'b0100);
        @(posedge clk);
        #1;
        chk("clip2_plot", rr_plot, 0);
        chk("clip2_count", rr_clip, 2);
        set_ch(2, 8'd159, 7'd119, COL_GREEN);
        @(posedge clk);
        #1;
        chk("clip3_plot", rr_plot, 1);
        chk("clip3_x", rr_x, 159);
        chk("clip3_y", rr_y, 119);
        chk("clip3_colour", rr_col, COL_GREEN);
        chk("clip3_gid", rr_gid, 2);
        chk("clip3_count", rr_clip, 2);

        // Enable gating and one-cycle latency on channel 0 (pointer wraps 3 -> 0).
        rr_if.in_valid = 4'b0001;
        set_ch(0, 8'd42, 7'd17, 3'b101);
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("en0_ready", rr_if.in_ready, 0);
            @(posedge clk);
            #1;
            chk("en0_plot", rr_plot, 0);
        end
        en = 1'b1;
        #1;
        chk("en1_ready", rr_if.in_ready, 4'b0001);
        @(posedge clk);
        #1;
        chk("en1_plot", rr_plot, 1);
        chk("en1_x", rr_x, 42);
        chk("en1_y", rr_y, 17);
        chk("en1_colour", rr_col, 3'b101);
        chk("en1_gid", rr_gid, 0);
        rr_if.in_valid = 4'b0000;
        @(posedge clk);
        #1;
        chk("en1_plot_drop", rr_plot, 0);
        chk("en1_x_hold", rr_x, 42);

        // Fixed priority instance.
        set_defaults();
        for (int k = 0; k < 7; k++) apply_row(1'b1, fp_tab[k]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
